// File: rtl/uut_harness_ctrl_if.sv
// ============================================================================
// Module   : uut_harness_ctrl_if
// Purpose  : Signal bundle between the run controller and the unit under test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uut_harness_ctrl_if #(
    parameter int IN1_W = 80,
    parameter int IN2_W = 80,
    parameter int OUT_W = 64
);
    logic             rst_uut;
    logic [IN1_W-1:0] in1_uut;
    logic [IN2_W-1:0] in2_uut;
    logic             end_uut;
    logic [OUT_W-1:0] out_uut;

    modport master (
        output rst_uut, in1_uut, in2_uut,
        input  end_uut, out_uut
    );

    modport slave (
        input  rst_uut, in1_uut, in2_uut,
        output end_uut, out_uut
    );
endinterface

`default_nettype wire

// File: rtl/uut_harness_ctrl.sv
// ============================================================================
// Module   : uut_harness_ctrl
// Purpose  : Latches operands, holds the UUT in reset, runs it, captures the
//            result and latency, flags timeouts, drives a 32-bit debug word.
//            Optional result comparator: define UUT_HARNESS_COMPARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uut_harness_ctrl #(
    parameter int IN1_W      = 80,
    parameter int IN2_W      = 80,
    parameter int OUT_W      = 64,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start_i,
    input  wire logic [IN1_W-1:0] in1_i,
    input  wire logic [IN2_W-1:0] in2_i,
    input  wire logic [OUT_W-1:0] expected_i,
    uut_harness_ctrl_if.master    uut,
    output logic      [OUT_W-1:0] result_o,
    output logic      [31:0]      cycles_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic      [15:0]      run_cnt_o,
    input  wire logic [1:0]       sw_debug,
    output logic      [31:0]      debug
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          LDW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [LDW-1:0] c_load_last = LDW'(RST_CYCLES - 1);
    localparam logic [31:0] c_timeout   = 32'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LDW-1:0]   r_load_cnt;
    logic [31:0]      r_run_k;
    logic             r_rst_uut;
    logic [IN1_W-1:0] r_in1;
    logic [IN2_W-1:0] r_in2;
    logic [OUT_W-1:0] r_result;
    logic [31:0]      r_cycles;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic [15:0]      r_run_cnt;
    logic [31:0]      r_debug;
    logic             w_pass;
    logic             w_start_ok;
    logic             w_end;
    logic             w_tmo;
    logic [31:0]      w_res_lo;
    logic [31:0]      w_res_hi;

`ifdef UUT_HARNESS_COMPARE_EN
    logic [OUT_W-1:0] r_expected;
    logic             r_pass;
    assign w_pass = r_pass;
`else
    assign w_pass = 1'b0;
`endif

    assign w_start_ok = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_end      = (r_state == ST_RUN) && uut.end_uut;
    // A completion on the very cycle the limit is reached still counts as success.
    assign w_tmo      = (r_state == ST_RUN) && !uut.end_uut && (r_run_k == c_timeout);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_ok)                 w_state_nxt = ST_LOAD;
            ST_LOAD:          if (r_load_cnt == c_load_last)  w_state_nxt = ST_RUN;
            ST_RUN:           if (w_end || w_tmo)             w_state_nxt = ST_DONE;
            default:                                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_load_cnt <= '0;
            r_run_k    <= '0;
            r_rst_uut  <= 1'b1;
            r_in1      <= '0;
            r_in2      <= '0;
            r_result   <= '0;
            r_cycles   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_run_cnt  <= '0;
`ifdef UUT_HARNESS_COMPARE_EN
            r_expected <= '0;
            r_pass     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_rst_uut <= (w_state_nxt != ST_RUN);
            r_busy    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);

            if (w_start_ok) begin
                r_in1      <= in1_i;
                r_in2      <= in2_i;
                r_result   <= '0;
                r_cycles   <= '0;
                r_timeout  <= 1'b0;
                r_load_cnt <= '0;
`ifdef UUT_HARNESS_COMPARE_EN
                r_expected <= expected_i;
                r_pass     <= 1'b0;
`endif
            end

            if (r_state == ST_LOAD) begin
                r_load_cnt <= r_load_cnt + LDW'(1);
                r_run_k    <= 32'd1;
            end

            if (r_state == ST_RUN) begin
                if (w_end) begin
                    r_result  <= uut.out_uut;
                    r_cycles  <= r_run_k;
                    r_run_cnt <= r_run_cnt + 16'd1;
`ifdef UUT_HARNESS_COMPARE_EN
                    r_pass    <= (uut.out_uut == r_expected);
`endif
                end else if (w_tmo) begin
                    r_timeout <= 1'b1;
                    r_result  <= '0;
                    r_cycles  <= c_timeout;
                    r_run_cnt <= r_run_cnt + 16'd1;
                end else begin
                    r_run_k   <= r_run_k + 32'd1;
                end
            end
        end
    end

    generate
        if (OUT_W >= 32) begin : g_lo_full
            assign w_res_lo = r_result[31:0];
        end else begin : g_lo_ext
            assign w_res_lo = {{(32-OUT_W){1'b0}}, r_result};
        end

        if (OUT_W >= 64) begin : g_hi_full
            assign w_res_hi = r_result[63:32];
        end else if (OUT_W > 32) begin : g_hi_ext
            assign w_res_hi = {{(64-OUT_W){1'b0}}, r_result[OUT_W-1:32]};
        end else begin : g_hi_zero
            assign w_res_hi = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_debug <= '0;
        end else begin
            case (sw_debug)
                2'b00:   r_debug <= w_res_lo;
                2'b01:   r_debug <= w_res_hi;
                2'b10:   r_debug <= r_cycles;
                default: r_debug <= {r_run_cnt, 12'h000, r_timeout, w_pass, r_done, r_busy};
            endcase
        end
    end

    assign uut.rst_uut = r_rst_uut;
    assign uut.in1_uut = r_in1;
    assign uut.in2_uut = r_in2;
    assign result_o    = r_result;
    assign cycles_o    = r_cycles;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = w_pass;
    assign timeout_o   = r_timeout;
    assign run_cnt_o   = r_run_cnt;
    assign debug       = r_debug;

endmodule

`default_nettype wire

// File: tb/tb_uut_harness_ctrl.sv
// ============================================================================
// Module   : tb_uut_harness_ctrl
// Purpose  : Directed self-checking bench; a long-timeout and a short-timeout
//            controller share the start/operand stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uut_harness_ctrl;

`ifdef UUT_HARNESS_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif
    localparam logic [63:0] GOLD = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [79:0] in1_i = '0;
    logic [79:0] in2_i = '0;
    logic [63:0] expected_i = '0;
    logic [1:0]  sw_debug = 2'b00;
    logic [63:0] out_val = GOLD;

    logic [63:0] res_l, res_t;
    logic [31:0] cyc_l, cyc_t, dbg_l, dbg_t;
    logic        busy_l, busy_t, done_l, done_t, pass_l, pass_t, tmo_l, tmo_t;
    logic [15:0] rc_l, rc_t;

    int cnt_l = 0, cnt_t = 0;
    int tgt_l = 0, tgt_t = 0;
    int checks = 0, failures = 0;
    int exp_rc_l = 0, exp_rc_t = 0;

    uut_harness_ctrl_if #(.IN1_W(80), .IN2_W(80), .OUT_W(64)) uif_l ();
    uut_harness_ctrl_if #(.IN1_W(80), .IN2_W(80), .OUT_W(64)) uif_t ();

    uut_harness_ctrl #(.IN1_W(80), .IN2_W(80), .OUT_W(64), .RST_CYCLES(4), .TIMEOUT(4096)) dut_l (
        .clk(clk), .rst(rst), .start_i(start_i), .in1_i(in1_i), .in2_i(in2_i),
        .expected_i(expected_i), .uut(uif_l), .result_o(res_l), .cycles_o(cyc_l),
        .busy_o(busy_l), .done_o(done_l), .pass_o(pass_l), .timeout_o(tmo_l),
        .run_cnt_o(rc_l), .sw_debug(sw_debug), .debug(dbg_l));

    uut_harness_ctrl #(.IN1_W(80), .IN2_W(80), .OUT_W(64), .RST_CYCLES(4), .TIMEOUT(100)) dut_t (
        .clk(clk), .rst(rst), .start_i(start_i), .in1_i(in1_i), .in2_i(in2_i),
        .expected_i(expected_i), .uut(uif_t), .result_o(res_t), .cycles_o(cyc_t),
        .busy_o(busy_t), .done_o(done_t), .pass_o(pass_t), .timeout_o(tmo_t),
        .run_cnt_o(rc_t), .sw_debug(sw_debug), .debug(dbg_t));

    always #5 clk = ~clk;

    // Stub UUTs: cnt is k-1 during the k-th cycle out of reset; tgt 0 = never finish.
    always @(posedge clk) begin
        cnt_l <= uif_l.rst_uut ? 0 : cnt_l + 1;
        cnt_t <= uif_t.rst_uut ? 0 : cnt_t + 1;
    end
    assign uif_l.end_uut = !uif_l.rst_uut && (tgt_l != 0) && (cnt_l == tgt_l - 1);
    assign uif_t.end_uut = !uif_t.rst_uut && (tgt_t != 0) && (cnt_t == tgt_t - 1);
    assign uif_l.out_uut = out_val;
    assign uif_t.out_uut = out_val;

    task automatic do_start(input logic [79:0] a, input logic [79:0] b, input logic [63:0] e);
        @(negedge clk);
        in1_i = a; in2_i = b; expected_i = e; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_both(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done_l && done_t) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (uif_l.rst_uut !== 1'b1) begin failures++; $display("FAIL reset_rst_uut got=%b want=1", uif_l.rst_uut); end
        checks++; if ({busy_l, done_l, pass_l, tmo_l} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {busy_l, done_l, pass_l, tmo_l}); end
        checks++; if ({res_l, cyc_l, rc_l, dbg_l} !== '0) begin failures++; $display("FAIL reset_regs got=%h want=0", {res_l, cyc_l, rc_l, dbg_l}); end
        checks++; if (uif_l.in1_uut !== 80'h0) begin failures++; $display("FAIL reset_in1 got=%h want=0", uif_l.in1_uut); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy_l, done_l, uif_l.rst_uut} !== 3'b001) begin failures++; $display("FAIL idle_after_reset got=%b want=001", {busy_l, done_l, uif_l.rst_uut}); end
    endtask

    task automatic test_latency;
        int n;
        bit ok;
        tgt_l = 1152; tgt_t = 0;
        do_start(80'hA1A2_A3A4_A5A6_A7A8_A9AA, 80'hB1B2_B3B4_B5B6_B7B8_B9BA, GOLD);
        checks++; if (busy_l !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy_l); end
        n = 0;
        while (uif_l.rst_uut && n < 20) begin n++; @(negedge clk); end
        checks++; if (n !== 4) begin failures++; $display("FAIL rst_uut_high_cycles got=%0d want=4", n); end
        checks++; if (uif_l.in1_uut !== 80'hA1A2_A3A4_A5A6_A7A8_A9AA || uif_l.in2_uut !== 80'hB1B2_B3B4_B5B6_B7B8_B9BA) begin
            failures++; $display("FAIL operands got=%h/%h", uif_l.in1_uut, uif_l.in2_uut); end
        wait_both(ok);
        checks++; if (!ok) begin failures++; $display("FAIL latency_wait got=timeout want=done"); end
        exp_rc_l++; exp_rc_t++;
        checks++; if (cyc_l !== 32'd1152) begin failures++; $display("FAIL latency_cycles got=%0d want=1152", cyc_l); end
        checks++; if (res_l !== GOLD) begin failures++; $display("FAIL latency_result got=%h want=%h", res_l, GOLD); end
        checks++; if ({done_l, busy_l, tmo_l, uif_l.rst_uut} !== 4'b1001) begin failures++; $display("FAIL latency_flags got=%b want=1001", {done_l, busy_l, tmo_l, uif_l.rst_uut}); end
        checks++; if (rc_l !== 16'(exp_rc_l)) begin failures++; $display("FAIL latency_run_cnt got=%0d want=%0d", rc_l, exp_rc_l); end
        checks++; if (pass_l !== CMP) begin failures++; $display("FAIL pass_match got=%b want=%b", pass_l, CMP); end
        checks++; if (tmo_t !== 1'b1 || cyc_t !== 32'd100) begin failures++; $display("FAIL short_dut_timeout got=%b/%0d want=1/100", tmo_t, cyc_t); end
    endtask

    task automatic test_debug;
        logic [31:0] want [4];
        want[0] = 32'h89AB_CDEF;
        want[1] = 32'h0123_4567;
        want[2] = 32'd1152;
        want[3] = {16'h0001, 12'h000, 1'b0, CMP, 1'b1, 1'b0};
        @(negedge clk);
        sw_debug = 2'b00;
        @(negedge clk);
        checks++; if (dbg_l !== want[0]) begin failures++; $display("FAIL debug_sel0 got=%h want=%h", dbg_l, want[0]); end
        for (int s = 1; s < 4; s++) begin
            sw_debug = 2'(s);
            #1;
            checks++; if (dbg_l !== want[s-1]) begin failures++; $display("FAIL debug_latency_sel%0d got=%h want=%h", s, dbg_l, want[s-1]); end
            @(negedge clk);
            checks++; if (dbg_l !== want[s]) begin failures++; $display("FAIL debug_sel%0d got=%h want=%h", s, dbg_l, want[s]); end
        end
        sw_debug = 2'b00;
    endtask

    task automatic test_compare_mismatch;
        bit ok;
        tgt_l = 10; tgt_t = 10;
        do_start(80'h1, 80'h2, 64'h0);
        wait_both(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mismatch_wait got=timeout want=done"); end
        exp_rc_l++; exp_rc_t++;
        checks++; if (pass_l !== 1'b0 || res_l !== GOLD || cyc_l !== 32'd10) begin
            failures++; $display("FAIL mismatch got=pass%b res=%h cyc=%0d want=pass0 res=%h cyc=10", pass_l, res_l, cyc_l, GOLD); end
        checks++; if (rc_l !== 16'(exp_rc_l)) begin failures++; $display("FAIL mismatch_run_cnt got=%0d want=%0d", rc_l, exp_rc_l); end
    endtask

    task automatic test_timeout;
        bit ok;
        tgt_l = 5; tgt_t = 0;
        do_start(80'h3, 80'h4, GOLD);
        wait_both(ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_wait got=timeout want=done"); end
        exp_rc_l++; exp_rc_t++;
        checks++; if (cyc_t !== 32'd100 || tmo_t !== 1'b1) begin failures++; $display("FAIL timeout_cycles got=%0d/%b want=100/1", cyc_t, tmo_t); end
        checks++; if (res_t !== 64'h0 || done_t !== 1'b1 || pass_t !== 1'b0) begin failures++; $display("FAIL timeout_result got=%h done%b pass%b want=0 done1 pass0", res_t, done_t, pass_t); end
        checks++; if (rc_t !== 16'(exp_rc_t)) begin failures++; $display("FAIL timeout_run_cnt got=%0d want=%0d", rc_t, exp_rc_t); end
    endtask

    task automatic test_end_at_timeout;
        bit ok;
        tgt_l = 5; tgt_t = 100;
        do_start(80'h5, 80'h6, GOLD);
        wait_both(ok);
        checks++; if (!ok) begin failures++; $display("FAIL edge_wait got=timeout want=done"); end
        exp_rc_l++; exp_rc_t++;
        checks++; if (tmo_t !== 1'b0 || cyc_t !== 32'd100) begin failures++; $display("FAIL end_at_limit got=tmo%b cyc=%0d want=tmo0 cyc=100", tmo_t, cyc_t); end
        checks++; if (res_t !== GOLD || pass_t !== CMP) begin failures++; $display("FAIL end_at_limit_result got=%h pass%b want=%h pass%b", res_t, pass_t, GOLD, CMP); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        tgt_l = 0; tgt_t = 0;
        do_start(80'h7, 80'h8, GOLD);
        n = 0;
        while (cnt_l != 49 && n < 200) begin n++; @(negedge clk); end
        checks++; if (cnt_l != 49 || uif_l.rst_uut !== 1'b0) begin failures++; $display("FAIL reach_run_cycle50 got=%0d want=49", cnt_l); end
        rst = 1'b1;
        #1;
        checks++; if (uif_l.rst_uut !== 1'b1 || busy_l !== 1'b0 || done_l !== 1'b0) begin
            failures++; $display("FAIL async_reset got=rst_uut%b busy%b done%b want=1,0,0", uif_l.rst_uut, busy_l, done_l); end
        @(negedge clk);
        rst = 1'b0;
        exp_rc_l = 0; exp_rc_t = 0;
        repeat (10) @(negedge clk);
        checks++; if (rc_l !== 16'h0 || busy_l !== 1'b0 || done_l !== 1'b0 || uif_l.rst_uut !== 1'b1) begin
            failures++; $display("FAIL after_mid_reset got=rc%0d busy%b done%b want=rc0 idle", rc_l, busy_l, done_l); end
    endtask

    task automatic test_start_ignored;
        int n;
        bit ok;
        tgt_l = 30; tgt_t = 20;
        do_start(80'hAAAA, 80'hBBBB, GOLD);
        n = 0;
        while (cnt_l != 9 && n < 100) begin n++; @(negedge clk); end
        in1_i = 80'hDEAD; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_both(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ignore_wait got=timeout want=done"); end
        exp_rc_l++; exp_rc_t++;
        checks++; if (cyc_l !== 32'd30 || res_l !== GOLD || rc_l !== 16'(exp_rc_l)) begin
            failures++; $display("FAIL start_ignored got=cyc%0d rc%0d want=cyc30 rc%0d", cyc_l, rc_l, exp_rc_l); end
        checks++; if (uif_l.in1_uut !== 80'hAAAA) begin failures++; $display("FAIL start_ignored_in1 got=%h want=aaaa", uif_l.in1_uut); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_debug();
        test_compare_mismatch();
        test_timeout();
        test_end_at_timeout();
        test_reset_mid_run();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
